// File: rtl/wino_load_scheduler.sv
// wino_load_scheduler
//
// Sequences one Winograd layer pass. Weight rows, then input-tile rows, are
// taken from a host valid/ready stream and written into the weight and input
// scan memories. The compute array is then launched and the pass completes
// when it reports done. This block is the only writer of both memories.
//
// Optional feature: define WINO_WGT_REUSE_EN to add the reuse_wgt input. A
// start with reuse_wgt=1, once a full weight set has been loaded since reset,
// skips the weight phase and goes straight to loading input rows.
//
// Ports
//   clock          clock
//   reset          synchronous, active-high reset
//   start          begin a layer pass (honoured only when idle)
//   reuse_wgt      (WINO_WGT_REUSE_EN only) keep previously loaded weights
//   host_valid     host_data carries a word
//   host_data      row payload
//   host_ready     a word is accepted this cycle (combinational from state)
//   wgt_wr_en      weight memory write strobe (registered)
//   inp_wr_en      input memory write strobe (registered)
//   wr_addr        row address for the active strobe (registered)
//   wr_data        row data for the active strobe (registered)
//   compute_start  one-cycle launch pulse to the compute array
//   compute_done   compute array finished; only looked at while waiting
//   busy           high whenever a pass is in progress
//   done           one-cycle pass-complete pulse

module wino_load_scheduler #(
  parameter int unsigned DATA_WIDTH = 288,
  parameter int unsigned WGT_ROWS   = 128,
  parameter int unsigned INP_ROWS   = 128,
  parameter int unsigned ADDR_W     = $clog2((WGT_ROWS > INP_ROWS) ? WGT_ROWS : INP_ROWS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
`ifdef WINO_WGT_REUSE_EN
  input  logic                  reuse_wgt,
`endif
  input  logic                  host_valid,
  input  logic [DATA_WIDTH-1:0] host_data,
  output logic                  host_ready,
  output logic                  wgt_wr_en,
  output logic                  inp_wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  compute_start,
  input  logic                  compute_done,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadWgt,
    StLoadInp,
    StLaunch,
    StWaitCmp,
    StFinish
  } state_e;

  localparam logic [ADDR_W-1:0] WgtLast = ADDR_W'(WGT_ROWS - 1);
  localparam logic [ADDR_W-1:0] InpLast = ADDR_W'(INP_ROWS - 1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] row_q;
  logic              xfer;
  logic              load_wgt_first;

`ifdef WINO_WGT_REUSE_EN
  logic wgt_loaded_q;
  assign load_wgt_first = !(reuse_wgt && wgt_loaded_q);
`else
  assign load_wgt_first = 1'b1;
`endif

  assign host_ready = (state_q == StLoadWgt) || (state_q == StLoadInp);
  assign xfer       = host_valid && host_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      row_q         <= '0;
      wgt_wr_en     <= 1'b0;
      inp_wr_en     <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      compute_start <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef WINO_WGT_REUSE_EN
      wgt_loaded_q  <= 1'b0;
`endif
    end else begin
      // Write port lags the handshake by one cycle; address and data only
      // move on a transfer, so they hold between strobes.
      wgt_wr_en     <= xfer && (state_q == StLoadWgt);
      inp_wr_en     <= xfer && (state_q == StLoadInp);
      if (xfer) begin
        wr_addr <= row_q;
        wr_data <= host_data;
      end
      compute_start <= 1'b0;
      done          <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            row_q   <= '0;
            busy    <= 1'b1;
            state_q <= load_wgt_first ? StLoadWgt : StLoadInp;
          end
        end
        StLoadWgt: begin
          if (host_valid) begin
            if (row_q == WgtLast) begin
              row_q        <= '0;
              state_q      <= StLoadInp;
`ifdef WINO_WGT_REUSE_EN
              wgt_loaded_q <= 1'b1;
`endif
            end else begin
              row_q <= row_q + AddrOne;
            end
          end
        end
        StLoadInp: begin
          if (host_valid) begin
            if (row_q == InpLast) begin
              row_q         <= '0;
              state_q       <= StLaunch;
              compute_start <= 1'b1;
            end else begin
              row_q <= row_q + AddrOne;
            end
          end
        end
        StLaunch: begin
          state_q <= StWaitCmp;
        end
        StWaitCmp: begin
          if (compute_done) begin
            state_q <= StFinish;
            done    <= 1'b1;
          end
        end
        StFinish: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wino_load_scheduler.sv
// Bench for wino_load_scheduler with 4 weight rows and 4 input rows.
// A pass-level model (words accepted so far, launch/finish flags) predicts
// every output each cycle; literal checks pin latency and memory contents.

module tb_wino_load_scheduler;

  localparam int unsigned DW    = 16;
  localparam int unsigned W     = 4;
  localparam int unsigned I     = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned TOTAL = W + I;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          host_valid;
  logic [DW-1:0] host_data;
  logic          host_ready;
  logic          wgt_wr_en;
  logic          inp_wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          compute_start;
  logic          compute_done;
  logic          busy;
  logic          done;
`ifdef WINO_WGT_REUSE_EN
  logic          reuse_wgt = 1'b0;
`endif

  wino_load_scheduler #(
    .DATA_WIDTH(DW),
    .WGT_ROWS  (W),
    .INP_ROWS  (I)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
`ifdef WINO_WGT_REUSE_EN
    .reuse_wgt    (reuse_wgt),
`endif
    .host_valid   (host_valid),
    .host_data    (host_data),
    .host_ready   (host_ready),
    .wgt_wr_en    (wgt_wr_en),
    .inp_wr_en    (inp_wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .compute_start(compute_start),
    .compute_done (compute_done),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return 16'hA000 + 16'(i);
  endfunction

  // Pass-level model: how many words this pass has accepted, whether the
  // launch cycle has passed, and whether the finish cycle is due.
  bit          m_active, m_launched, m_finishing, m_loaded;
  int          m_xfers;
  bit          m_rdy, m_cst, m_reuse;
  bit          e_wgt, e_inp, e_fresh;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  always @(posedge clock) begin
`ifdef WINO_WGT_REUSE_EN
    m_reuse = reuse_wgt;
`else
    m_reuse = 1'b0;
`endif
    m_rdy = m_active && (m_xfers < TOTAL);
    m_cst = m_active && (m_xfers == TOTAL) && !m_launched;
    if (reset) begin
      m_active = 0; m_launched = 0; m_finishing = 0; m_loaded = 0; m_xfers = 0;
      e_wgt = 0; e_inp = 0; e_addr = '0; e_data = '0; e_fresh = 1;
    end else begin
      e_fresh = 0;
      e_wgt   = m_rdy && host_valid && (m_xfers < W);
      e_inp   = m_rdy && host_valid && (m_xfers >= W);
      if (m_rdy && host_valid) begin
        e_addr = (m_xfers < W) ? AW'(m_xfers) : AW'(m_xfers - W);
        e_data = host_data;
      end
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_launched = 0; m_finishing = 0;
          m_xfers = (m_reuse && m_loaded) ? W : 0;
        end
      end else if (m_rdy) begin
        if (host_valid) begin
          m_xfers++;
          if (m_xfers == W) m_loaded = 1;
        end
      end else if (m_cst) begin
        m_launched = 1;
      end else if (m_finishing) begin
        m_active = 0; m_finishing = 0;
      end else if (compute_done) begin
        m_finishing = 1;
      end
    end
  end

  // Per-cycle compare plus shadow copies of what the DUT wrote.
  bit            checking = 0;
  logic [DW-1:0] sh_wgt [W];
  logic [DW-1:0] sh_inp [I];
  int            n_wgt_wr, n_inp_wr, n_done;

  always @(negedge clock) begin
    if (checking) begin
      chk("host_ready", 32'(host_ready), 32'(m_active && (m_xfers < TOTAL)));
      chk("busy", 32'(busy), 32'(m_active));
      chk("compute_start", 32'(compute_start),
          32'(m_active && (m_xfers == TOTAL) && !m_launched));
      chk("done", 32'(done), 32'(m_finishing));
      chk("wgt_wr_en", 32'(wgt_wr_en), 32'(e_wgt));
      chk("inp_wr_en", 32'(inp_wr_en), 32'(e_inp));
      if (e_wgt || e_inp || e_fresh) begin
        chk("wr_addr", 32'(wr_addr), 32'(e_addr));
        chk("wr_data", 32'(wr_data), 32'(e_data));
      end
      if (wgt_wr_en) begin sh_wgt[wr_addr] = wr_data; n_wgt_wr++; end
      if (inp_wr_en) begin sh_inp[wr_addr] = wr_data; n_inp_wr++; end
      if (done) n_done++;
    end
  end

  // Host side: one cycle per tick, next word presented after each accept.
  bit accepted, done_seen, cstart_seen;
  int w_idx;

  task automatic tick();
    @(negedge clock);
    accepted    = host_valid && host_ready;
    done_seen   = done;
    cstart_seen = compute_start;
    @(posedge clock);
    #1;
    if (accepted) begin
      w_idx++;
      host_data = word(w_idx);
    end
  endtask

  task automatic clear_shadow();
    for (int k = 0; k < W; k++) sh_wgt[k] = '0;
    for (int k = 0; k < I; k++) sh_inp[k] = '0;
    n_wgt_wr = 0; n_inp_wr = 0; n_done = 0;
  endtask

  // Runs one pass. gap: idle WAIT cycles before compute_done. toggle: host
  // valid alternates. poke: stray start/compute_done in the wrong states.
  task automatic run_pass(input int gap, input bit toggle, input bit poke, output int done_tick);
    int  n_acc, wait_left;
    bit  poked;
    n_acc = 0; wait_left = -1; poked = 0; done_tick = 0;
    clear_shadow();
    w_idx = 0; host_data = word(0); host_valid = 1; start = 1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      start = 0; compute_done = 0;
      if (accepted) n_acc++;
      if (done_seen) begin done_tick = n; break; end
      if (toggle) host_valid = ~host_valid;
      if (poke && n == 3) compute_done = 1;
      if (poke && !poked && n_acc == W + 1) begin start = 1; poked = 1; end
      if (cstart_seen) wait_left = gap;
      if (wait_left == 0) begin
        compute_done = 1; wait_left = -1;
      end else if (wait_left > 0) begin
        wait_left--;
        if (poke) start = 1;
      end
    end
    if (done_tick == 0) chk("pass_done_timeout", 32'(0), 32'(1));
    host_valid = 0;
    tick(); tick();
    chk("done_pulses", 32'(n_done), 32'(1));
  endtask

  task automatic check_mem(input string tag, input int wgt_writes, input int inp_base);
    chk({tag, "_wgt_writes"}, 32'(n_wgt_wr), 32'(wgt_writes));
    chk({tag, "_inp_writes"}, 32'(n_inp_wr), 32'(I));
    if (wgt_writes != 0)
      for (int k = 0; k < W; k++) chk({tag, "_wgt_row"}, 32'(sh_wgt[k]), 32'(word(k)));
    for (int k = 0; k < I; k++) chk({tag, "_inp_row"}, 32'(sh_inp[k]), 32'(word(inp_base + k)));
  endtask

  int dt;

  initial begin
    reset = 1; start = 0; host_valid = 0; host_data = '0; compute_done = 0; w_idx = 0;
    clear_shadow();
    repeat (3) tick();
    checking = 1;
    chk("rst_host_ready", 32'(host_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_wr_addr", 32'(wr_addr), 32'(0));
    chk("rst_wr_data", 32'(wr_data), 32'(0));
    reset = 0;
    tick();

    // Full-rate pass, compute_done two cycles after entering WAIT.
    run_pass(2, 1'b0, 1'b0, dt);
    chk("full_rate_done_tick", 32'(dt), 32'(14));
    check_mem("full", W, W);

    // Valid toggling with stray start and compute_done pokes.
    run_pass(2, 1'b1, 1'b1, dt);
    chk("toggle_done_tick", 32'(dt), 32'(22));
    check_mem("toggle", W, W);

    // Reset after two weight rows have been accepted.
    clear_shadow();
    w_idx = 0; host_data = word(0); host_valid = 1; start = 1;
    tick(); start = 0;
    tick(); tick();
    reset = 1;
    tick();
    chk("mid_rst_wgt_writes", 32'(n_wgt_wr), 32'(2));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_host_ready", 32'(host_ready), 32'(0));
    chk("mid_rst_wgt_wr_en", 32'(wgt_wr_en), 32'(0));
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'(0));
    reset = 0; host_valid = 0;
    tick();
    run_pass(0, 1'b0, 1'b0, dt);
    chk("after_rst_done_tick", 32'(dt), 32'(12));
    check_mem("after_rst", W, W);

`ifdef WINO_WGT_REUSE_EN
    // Weights already loaded: input row 0 gets the first word.
    reuse_wgt = 1;
    run_pass(1, 1'b0, 1'b0, dt);
    check_mem("reuse", 0, 0);
    reset = 1; tick(); reset = 0; tick();
    run_pass(1, 1'b0, 1'b0, dt);
    check_mem("reuse_after_rst", W, W);
    reuse_wgt = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wino_load_scheduler.md
# wino_load_scheduler

Sequences one Winograd layer pass: streams weight rows, then input-tile rows, from a host valid/ready interface into the weight and input scan memories, then launches the compute array and waits for completion. Sits between the host/DMA stream and the two row-addressed memories feeding the Winograd datapath; it is the only writer of both memories.

## Interface

- DATA_WIDTH, 288, width of one host word and one memory row
- WGT_ROWS, 128, weight memory rows per layer (≥2)
- INP_ROWS, 128, input-tile memory rows per layer (≥2)
- ADDR_W, $clog2(max(WGT_ROWS,INP_ROWS)), row address width

- clock  in  1  clock
- reset  in  1  reset; synchronous, active-high
- start  in  1  begin a layer pass; honoured only in IDLE
- host_valid  in  1  host_data valid
- host_data  in  DATA_WIDTH  row payload
- host_ready  out  1  scheduler accepts a word this cycle
- wgt_wr_en  out  1  write strobe, weight memory
- inp_wr_en  out  1  write strobe, input memory
- wr_addr  out  ADDR_W  row address for the active strobe
- wr_data  out  DATA_WIDTH  row data for the active strobe
- compute_start  out  1  one-cycle launch pulse to compute array
- compute_done  in  1  compute array finished (pulse or level)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pass-complete pulse

## Operation

- States: IDLE, LOAD_WGT, LOAD_INP, LAUNCH, WAIT_CMP, FINISH.
- IDLE: start=1 → LOAD_WGT, row counter cleared. start in any other state is ignored.
- Handshake: a word transfers when host_valid && host_ready. host_ready = 1 exactly in LOAD_WGT and LOAD_INP (combinational from state); host_data is don't-care otherwise.
- LOAD_WGT: each transfer writes row = counter, counter+1. Transfer at counter == WGT_ROWS-1 → LOAD_INP, counter cleared.
- LOAD_INP: same, bound INP_ROWS-1 → LAUNCH.
- LAUNCH: compute_start=1 for exactly this one cycle → WAIT_CMP.
- WAIT_CMP: compute_done=1 → FINISH. compute_done outside WAIT_CMP is ignored.
- FINISH: done=1 for this cycle → IDLE.
- Counter never exceeds the row bound; no wrap within a phase. host_valid gaps stall the counter with no write.
- wgt_wr_en and inp_wr_en are never high together.

## Timing

- Write outputs registered: handshake in cycle N → strobe, wr_addr, wr_data valid in N+1 for one cycle; strobe low when no transfer in N.
- Full-rate: back-to-back transfers give back-to-back strobes, one row per cycle.
- State transition after the last row takes effect the next edge; first LOAD_INP handshake can occur one cycle after the last weight handshake.
- Minimum pass latency, start to done: WGT_ROWS + INP_ROWS + 3 cycles plus compute wait (compute_done sampled the cycle after compute_start at earliest).
- Reset values: host_ready 0, wgt_wr_en 0, inp_wr_en 0, wr_addr 0, wr_data 0, compute_start 0, busy 0, done 0; state IDLE, counter 0.
- Reset mid-pass: abort immediately, next cycle all outputs at reset values; any pending registered write is dropped. Partial memory contents are invalid.
- start asserted in the same cycle as done (FINISH): ignored; a new pass needs start in IDLE.

## Configuration

- WINO_WGT_REUSE_EN defined: adds input reuse_wgt (1 bit) and internal flag wgt_loaded (set on LOAD_WGT completion, cleared by reset). start with reuse_wgt=1 and wgt_loaded=1 → IDLE goes directly to LOAD_INP; otherwise LOAD_WGT as normal.
- Not defined: no reuse_wgt port; every pass loads weights.

## Test plan

- Full-rate pass, WGT_ROWS=INP_ROWS=4, host_valid held 1 → wgt_wr_en rows 0..3 then inp_wr_en rows 0..3 with matching data, compute_start one pulse, done one cycle after compute_done.
- host_valid toggling 1/0 → strobes only after accepted words, addresses contiguous 0..3, no duplicate or skipped rows.
- start pulsed during LOAD_INP and WAIT_CMP → no effect; pass completes once.
- reset asserted after 2 weight rows → next cycle busy=0, host_ready=0, no strobes; new start reloads weight row 0.
- compute_done pulsed in LOAD_WGT → ignored; WAIT_CMP still waits for a later compute_done.
- WINO_WGT_REUSE_EN: second pass with reuse_wgt=1 → no wgt_wr_en, first accepted word goes to input row 0; after reset, reuse_wgt=1 still loads weights.
